// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state
// encoding, operation mode constants and the counter-width helper.
package serial_add_sub_pkg;

    // Controller states: waiting for operands, shifting bits, holding result
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // The cin input doubles as the mode select and the LSB carry-in
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Number of bits needed to count 0..value-1
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_add_sub_full_adder.sv
// Single-bit full adder: the one arithmetic slice shared by every bit
// position of the serial adder/subtractor.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic half_sum;

    assign half_sum = a ^ b;
    assign s        = half_sum ^ ci;
    assign co       = (a & b) | (ci & half_sum);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor with valid/ready on both sides.
// One operand pair is accepted, processed LSB first through a single
// full-adder slice and a carry flop, and the result is held until the
// consumer takes it.
//
// Optional feature: define SERIAL_ADD_SUB_OVF_EN to add the ovf output
// (signed overflow, carry-into-MSB XOR carry-out, valid with out_valid).
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef SERIAL_ADD_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Bit counter must hold 0..WIDTH-1; keep at least one bit
    localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t state_q;
    state_t state_d;

    logic accept;
    logic shifting;
    logic last_bit;

    // Operand A register; sum bits enter at the MSB as A bits leave at the
    // LSB, so after WIDTH shifts it holds the complete result.
    logic [WIDTH-1:0] acc_p0;
    logic [WIDTH-1:0] opb_p0;
    logic             mode_p0;
    logic             carry_p0;
    logic [CNT_W-1:0] cnt_p0;

    logic             fa_b;
    logic             sum_bit;
    logic             carry_bit;

    // Result registers seen by the consumer; separate from the shift
    // register so they stay put while a new operation is shifting.
    logic [WIDTH-1:0] s_p1;
    logic             cout_p1;
    logic             vld_p1;

    assign accept   = in_valid && (state_q == ST_IDLE);
    assign shifting = (state_q == ST_SHIFT);
    assign last_bit = shifting && (cnt_p0 == LAST_BIT);

    // Subtraction feeds the inverted B bit; the +1 comes from the carry preload
    assign fa_b = opb_p0[0] ^ (mode_p0 == MODE_SUB);

    full_adder u_slice (
        .a  (acc_p0[0]),
        .b  (fa_b),
        .ci (carry_p0),
        .s  (sum_bit),
        .co (carry_bit)
    );

    // State register; reset abandons any operation in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept -> WIDTH shift cycles -> hold until taken
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_p0 == LAST_BIT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the registered state only
    always_comb begin
        in_ready = 1'b0;
        vld_p1   = 1'b0;
        case (state_q)
            ST_IDLE: in_ready = 1'b1;
            ST_DONE: vld_p1   = 1'b1;
            default: begin
                in_ready = 1'b0;
                vld_p1   = 1'b0;
            end
        endcase
    end

    // Operand capture and LSB-first shifting; reloaded on every accept
    always_ff @(posedge clk) begin
        if (accept) begin
            acc_p0  <= a;
            opb_p0  <= b;
            mode_p0 <= cin ? MODE_SUB : MODE_ADD;
        end else if (shifting) begin
            acc_p0 <= {sum_bit, acc_p0[WIDTH-1:1]};
            opb_p0 <= {1'b0, opb_p0[WIDTH-1:1]};
        end
    end

    // Carry flop preloaded with cin, bit counter cleared on accept
    always_ff @(posedge clk) begin
        if (accept) begin
            carry_p0 <= cin;
            cnt_p0   <= '0;
        end else if (shifting) begin
            carry_p0 <= carry_bit;
            cnt_p0   <= cnt_p0 + CNT_W'(1);
        end
    end

    // Result load on the final bit; held through DONE and beyond
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_p1    <= '0;
            cout_p1 <= 1'b0;
        end else if (last_bit) begin
            s_p1    <= {sum_bit, acc_p0[WIDTH-1:1]};
            cout_p1 <= carry_bit;
        end
    end

`ifdef SERIAL_ADD_SUB_OVF_EN
    logic ovf_p1;

    // Signed overflow: carry into the MSB differs from carry out of it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_p1 <= 1'b0;
        end else if (last_bit) begin
            ovf_p1 <= carry_p0 ^ carry_bit;
        end
    end

    assign ovf = ovf_p1;
`endif

    assign s         = s_p1;
    assign cout      = cout_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub (WIDTH = 4). Expected results are
// computed from plain integer add/subtract semantics.
module tb_serial_add_sub;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
`ifdef SERIAL_ADD_SUB_OVF_EN
    logic         ovf;
`endif

    int tests;
    int fails;

    serial_add_sub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout)
`ifdef SERIAL_ADD_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: true integer result of a+b or a-b
    function automatic int ref_int(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int xv;
        int yv;
        xv = int'(x);
        yv = int'(y);
        return c ? (xv - yv) : (xv + yv);
    endfunction

    function automatic logic [W-1:0] ref_s(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int r;
        r = ref_int(x, y, c);
        return W'(r);
    endfunction

    // Add: carry when the sum does not fit; subtract: carry means no borrow
    function automatic logic ref_cout(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        if (c) return (x >= y);
        return (ref_int(x, y, c) >= (1 << W));
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int xs;
        int ys;
        int r;
        xs = int'($signed(x));
        ys = int'($signed(y));
        r  = c ? (xs - ys) : (xs + ys);
        return (r > ((1 << (W - 1)) - 1)) || (r < -(1 << (W - 1)));
    endfunction

    function automatic logic get_ovf();
`ifdef SERIAL_ADD_SUB_OVF_EN
        return ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Drives one full transaction; returns what was observed, no checking
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          input int stall_pct,
                          output logic [W-1:0] rs, output logic rc, output logic ro,
                          output int lat, output bit tmo, output bit unstable);
        bit got;
        bit done;
        int n;
        tmo      = 1'b0;
        unstable = 1'b0;
        lat      = 0;
        rs       = '0;
        rc       = 1'b0;
        ro       = 1'b0;
        a        = ta;
        b        = tb_v;
        cin      = tc;
        in_valid = 1'b1;
        got      = 1'b0;
        n        = 0;
        while (!got && n < 50) begin
            got = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = 1'($urandom);
        if (!got) begin
            tmo = 1'b1;
            return;
        end
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            lat++;
            if (out_valid) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            tmo = 1'b1;
            return;
        end
        rs   = s;
        rc   = cout;
        ro   = get_ovf();
        done = 1'b0;
        n    = 0;
        while (!done && n < 200) begin
            out_ready = ($urandom_range(99) >= stall_pct);
            if (out_valid !== 1'b1 || s !== rs || cout !== rc || get_ovf() !== ro) unstable = 1'b1;
            @(posedge clk);
            #1;
            n++;
            if (out_ready) done = 1'b1;
        end
        out_ready = 1'b0;
        if (!done) tmo = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++; if (s !== 4'b0000) begin fails++; $display("FAIL reset_s: got %b want 0000", s); end
        tests++; if (cout !== 1'b0) begin fails++; $display("FAIL reset_cout: got %b want 0", cout); end
`ifdef SERIAL_ADD_SUB_OVF_EN
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL idle_after_reset: got rdy=%b vld=%b want 1 0", in_ready, out_valid); end
    endtask

    task automatic test_add_wrap();
        logic [W-1:0] rs;
        logic rc, ro;
        int lat;
        bit tmo, uns;
        run_op(4'd15, 4'd1, 1'b0, 0, rs, rc, ro, lat, tmo, uns);
        tests++; if (tmo) begin fails++; $display("FAIL add_wrap_timeout: got timeout want completion"); end
        tests++; if (lat !== W + 1) begin fails++; $display("FAIL add_wrap_latency: got %0d want %0d", lat, W + 1); end
        tests++; if (rs !== 4'b0000) begin fails++; $display("FAIL add_wrap_s: got %b want 0000", rs); end
        tests++; if (rc !== 1'b1) begin fails++; $display("FAIL add_wrap_cout: got %b want 1", rc); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL add_wrap_vld_one_cycle: got %b want 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL add_wrap_ready_back: got %b want 1", in_ready); end
        tests++; if (s !== 4'b0000 || cout !== 1'b1) begin fails++; $display("FAIL add_wrap_hold: got %b/%b want 0000/1", s, cout); end
    endtask

    task automatic test_subtract();
        logic [W-1:0] rs;
        logic rc, ro;
        int lat;
        bit tmo, uns;
        run_op(4'd5, 4'd3, 1'b1, 0, rs, rc, ro, lat, tmo, uns);
        tests++; if (tmo || rs !== 4'b0010 || rc !== 1'b1) begin fails++; $display("FAIL sub_5_3: got s=%b cout=%b tmo=%0b want 0010 1 0", rs, rc, tmo); end
        run_op(4'd3, 4'd5, 1'b1, 0, rs, rc, ro, lat, tmo, uns);
        tests++; if (tmo || rs !== 4'b1110 || rc !== 1'b0) begin fails++; $display("FAIL sub_3_5: got s=%b cout=%b tmo=%0b want 1110 0 0", rs, rc, tmo); end
    endtask

    task automatic test_backpressure();
        bit got;
        int n;
        a        = 4'd9;
        b        = 4'd4;
        cin      = 1'b0;
        in_valid = 1'b1;
        got      = 1'b0;
        n        = 0;
        while (!got && n < 50) begin
            got = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n         = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests++; if (!got || out_valid !== 1'b1) begin fails++; $display("FAIL bp_start: got accept=%0b vld=%b want 1 1", got, out_valid); end
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a        = W'($urandom);
            b        = W'($urandom);
            cin      = 1'($urandom);
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || s !== 4'b1101 || cout !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b s=%b cout=%b want 1 0 1101 0", i, out_valid, in_ready, s, cout);
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL bp_release: got vld=%b rdy=%b want 0 1", out_valid, in_ready); end
        for (int i = 0; i < W + 3; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || s !== 4'b1101) begin
                fails++;
                $display("FAIL bp_no_accept[%0d]: got vld=%b rdy=%b s=%b want 0 1 1101", i, out_valid, in_ready, s);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] rs;
        logic rc, ro;
        int lat;
        bit tmo, uns;
        bit seen;
        a        = 4'd7;
        b        = 4'd7;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || s !== 4'b0000 || cout !== 1'b0 || get_ovf() !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_outputs: got rdy=%b vld=%b s=%b cout=%b want 1 0 0000 0", in_ready, out_valid, s, cout);
        end
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < W + 3; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        tests++; if (seen || s !== 4'b0000) begin fails++; $display("FAIL mid_reset_discard: got vld_seen=%0b s=%b want 0 0000", seen, s); end
        run_op(4'd2, 4'd1, 1'b0, 0, rs, rc, ro, lat, tmo, uns);
        tests++; if (tmo || rs !== 4'b0011 || rc !== 1'b0) begin fails++; $display("FAIL mid_reset_next_op: got s=%b cout=%b tmo=%0b want 0011 0 0", rs, rc, tmo); end
    endtask

    task automatic test_sweep();
        logic [W-1:0] rs;
        logic rc, ro;
        int lat;
        bit tmo, uns;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic c;
        for (int ci = 0; ci < 2; ci++) begin
            for (int xi = 0; xi < (1 << W); xi++) begin
                for (int yi = 0; yi < (1 << W); yi++) begin
                    x = W'(xi);
                    y = W'(yi);
                    c = 1'(ci);
                    run_op(x, y, c, 30, rs, rc, ro, lat, tmo, uns);
                    tests++;
                    if (tmo || lat !== W + 1) begin
                        fails++;
                        $display("FAIL sweep_timing a=%0d b=%0d c=%0d: got lat=%0d tmo=%0b want %0d 0", x, y, c, lat, tmo, W + 1);
                    end
                    tests++;
                    if (rs !== ref_s(x, y, c) || rc !== ref_cout(x, y, c)) begin
                        fails++;
                        $display("FAIL sweep_result a=%0d b=%0d c=%0d: got s=%b cout=%b want %b %b", x, y, c, rs, rc, ref_s(x, y, c), ref_cout(x, y, c));
                    end
                    tests++;
                    if (uns) begin
                        fails++;
                        $display("FAIL sweep_stable a=%0d b=%0d c=%0d: got unstable=1 want 0", x, y, c);
                    end
`ifdef SERIAL_ADD_SUB_OVF_EN
                    tests++;
                    if (ro !== ref_ovf(x, y, c)) begin
                        fails++;
                        $display("FAIL sweep_ovf a=%0d b=%0d c=%0d: got %b want %b", x, y, c, ro, ref_ovf(x, y, c));
                    end
`endif
                end
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] rs;
        logic rc, ro;
        int lat;
        bit tmo, uns;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic c;
        for (int i = 0; i < 40; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            c = 1'($urandom);
            run_op(x, y, c, int'($urandom_range(80)), rs, rc, ro, lat, tmo, uns);
            tests++;
            if (tmo || uns || rs !== ref_s(x, y, c) || rc !== ref_cout(x, y, c)) begin
                fails++;
                $display("FAIL random[%0d] a=%0d b=%0d c=%0d: got s=%b cout=%b tmo=%0b uns=%0b want %b %b 0 0",
                         i, x, y, c, rs, rc, tmo, uns, ref_s(x, y, c), ref_cout(x, y, c));
            end
        end
`ifdef SERIAL_ADD_SUB_OVF_EN
        run_op(4'd7, 4'd1, 1'b0, 0, rs, rc, ro, lat, tmo, uns);
        tests++; if (tmo || ro !== 1'b1 || rs !== 4'b1000) begin fails++; $display("FAIL ovf_7_plus_1: got ovf=%b s=%b want 1 1000", ro, rs); end
`endif
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        rst_n     = 1'b0;
        test_reset();
        test_add_wrap();
        test_subtract();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_add_sub.md
# serial_add_sub

Bit-serial WIDTH-bit adder/subtractor with valid/ready handshakes on both sides. It is the responder for any operand initiator (bench sweep, sequencer, or CPU datapath) that would otherwise drive the combinational adder-subtractor. It accepts one operand pair plus a mode/carry bit and processes one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop. It returns sum and carry-out with the same arithmetic as the combinational unit.

## Interface
Parameters:
- WIDTH, 4, operand/sum width; legal range 2..32

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operand pair
- a  in  WIDTH  operand A, unsigned/two's complement
- b  in  WIDTH  operand B
- cin  in  1  0 = add (a+b), 1 = subtract (a-b); also the LSB carry-in
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- s  out  WIDTH  sum/difference
- cout  out  1  carry out of the MSB
- ovf  out  1  signed overflow; present only with SERIAL_ADD_SUB_OVF_EN

## Operation
- Arithmetic: {cout,s} = a + (b XOR {WIDTH{cin}}) + cin, computed in WIDTH+1 bits.
  - Subtract: cout=1 means a >= b unsigned, i.e. no borrow.
- FSM has three states:
  - IDLE: in_ready=1. On in_valid && in_ready, capture a, b, cin into shift registers and go to SHIFT. Preload the carry flop with cin and reset the bit counter to 0.
  - SHIFT: each cycle, add bit 0 of A, bit 0 of (B XOR cin) and the carry flop. Shift the sum bit into the MSB of the result register, shift A and B right, update the carry flop and increment the counter. After the bit at counter = WIDTH-1, go to DONE.
  - DONE: out_valid=1. s and cout come from the result register and carry flop. On out_ready, go to IDLE.
- Inputs a, b, cin are sampled only at the accepting edge. Later changes are ignored.
- s, cout and ovf stay stable while out_valid=1. They keep their last value after the result handshake until the next result is loaded.
- in_ready=0 in SHIFT and DONE. There is no overlap of a new operand with a pending result.
- Reset value of every output: in_ready=1, out_valid=0, s=0, cout=0, ovf=0.
- Reset mid-operation (SHIFT or DONE): the operation is discarded without a result, all outputs take their reset values, and the state becomes IDLE.

## Timing
- Accept at edge k. Bits are computed on edges k+1..k+WIDTH, and out_valid rises after edge k+WIDTH.
- Latency is WIDTH+1 cycles from the accept cycle to the first out_valid cycle.
- If out_ready is held high, out_valid lasts one cycle and in_ready returns the next cycle.
- Minimum issue interval is WIDTH+2 cycles.
- out_ready low holds DONE indefinitely with no timeout.
- in_valid while in_ready=0 is ignored. The initiator must hold in_valid until the handshake.
- No combinational path from any input to any output.

## Configuration
- SERIAL_ADD_SUB_OVF_EN defined:
  - Adds the ovf port and one flop capturing carry-into-MSB XOR carry-out on the final SHIFT cycle.
  - ovf is valid together with out_valid.
- Not defined: no ovf port and no extra logic. s and cout behaviour is identical either way.

## Structure
- Shared package serial_add_sub_pkg holds:
  - the state enum (ST_IDLE, ST_SHIFT, ST_DONE);
  - mode constants MODE_ADD=1'b0 and MODE_SUB=1'b1;
  - the counter-width function clog2(WIDTH).
- One sub-module: full_adder (a, b, ci -> s, co), instantiated once for the serial bit slice.

## Test plan
- Reset then idle: hold rst_n=0 for 2 cycles -> in_ready=1, out_valid=0, s=0, cout=0 (ovf=0).
- Add with wrap: a=15, b=1, cin=0, out_ready=1 -> out_valid exactly WIDTH+1=5 cycles after accept; s=0000, cout=1; in_ready back the next cycle.
- Subtract, both signs:
  - a=5, b=3, cin=1 -> s=0010, cout=1.
  - a=3, b=5, cin=1 -> s=1110, cout=0.
- Backpressure: a=9, b=4, cin=0, out_ready=0 for 10 cycles -> out_valid=1 and s=1101, cout=0 stable throughout. in_valid pulses during this time are not accepted. Raising out_ready completes the handshake.
- Reset mid-SHIFT: accept a=7, b=7, cin=0, then assert rst_n=0 two cycles later -> no out_valid, outputs at reset values. The next operation a=2, b=1, cin=0 gives s=0011.
- Exhaustive sweep (both macro settings): all 16x16 a/b pairs for cin=0 and cin=1 with random out_ready stalls -> s, cout match the reference arithmetic. With the macro, ovf=1 exactly for signed overflow (e.g. a=7, b=1, cin=0 -> ovf=1).
